frame_checker: RTL and testbench
================================

# frame_checker

Receive-side framing stage between `uart_rx` and `parser` in the nonogram solver. It validates each board frame arriving over UART (sync byte, length, XOR checksum), buffers the payload, and forwards it to `parser` only when the whole frame is intact. A corrupted, truncated or oversized frame therefore never reaches `parser` or the solve pipeline. It also reports per-frame status for the debug probes.

## Interface
Parameters:
- `MAX_PAYLOAD`, 64: payload buffer depth in bytes; the largest legal length field.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 5_000_000: maximum idle gap between bytes inside a frame (100 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; the 50 MHz domain.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `valid_in`  in  1  one-cycle strobe from `uart_rx`; `byte_in` is valid.
- `byte_in`  in  8  received byte.
- `out_ready`  in  1  downstream may take a byte this cycle.
- `valid_out`  out  1  one-cycle strobe to `parser`; `byte_out` is valid.
- `byte_out`  out  8  forwarded payload byte.
- `frame_ok`  out  1  one-cycle pulse: checksum matched and replay is starting.
- `frame_err`  out  1  one-cycle pulse: frame discarded.
- `err_code`  out  2  cause of the error, valid while `frame_err`=1: 1 bad length, 2 checksum mismatch, 3 timeout. Holds its last value otherwise.
- `busy`  out  1  high in every state except HUNT.
- `drop_count`  out  8  saturating count of bytes dropped during REPLAY.

## Operation
- Frame format on the wire: SYNC_BYTE, then L (1..MAX_PAYLOAD), then L payload bytes, then CSUM. CSUM = L XOR every payload byte.
- States: HUNT, LEN, PAYLOAD, CSUM, REPLAY.
- HUNT: wait for a byte.
  - A byte equal to SYNC_BYTE moves to LEN.
  - Any other byte is ignored silently; no error is raised.
- LEN: take the length byte L.
  - L=0 or L>MAX_PAYLOAD: go to HUNT and raise `frame_err` with code 1.
  - Otherwise store L, set the running XOR to L, clear the write index, and go to PAYLOAD.
- PAYLOAD: write each byte to `buf[wr]`, increment `wr`, and XOR the byte into the running value.
  - When the byte with index L-1 is written, go to CSUM.
- CSUM: compare the received byte with the running XOR.
  - Match: go to REPLAY and raise `frame_ok`.
  - Mismatch: go to HUNT and raise `frame_err` with code 2.
- REPLAY: on each cycle with `out_ready`=1, register `byte_out`=`buf[rd]`, set `valid_out`=1, and increment `rd`.
  - After emitting index L-1, go to HUNT.
  - Any `valid_in` seen in REPLAY is dropped and increments `drop_count`, which saturates at 255.
- Timeout applies in LEN, PAYLOAD and CSUM.
  - The idle counter clears on every `valid_in` and on every state entry.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, go to HUNT and raise `frame_err` with code 3.
- A SYNC_BYTE value received inside LEN, PAYLOAD or CSUM is ordinary data. There is no resync mid-frame.
- A new frame fully overwrites the buffer; no stale contents are used.
- Reset (`rst`=0 at a clock edge) applies mid-operation too: state goes to HUNT, the frame is abandoned, and no error is reported.
  - `valid_out`, `byte_out`, `frame_ok`, `frame_err`, `err_code`, `busy` and `drop_count` all reset to 0.
  - Indices, the running XOR and the idle counter clear.

## Timing
- Every output is registered.
- `frame_ok` and `frame_err` are high for exactly one cycle and never high together.
- Checksum byte accepted at edge t:
  - `frame_ok` or `frame_err` is high during cycle t+1.
  - With `out_ready` held high, `valid_out` is high in cycles t+2 through t+1+L, one byte per cycle, in order.
- If `out_ready` drops, `valid_out` is 0 on the following cycle. Replay resumes at the same index with no byte skipped or repeated.
- `busy` falls on the same cycle the last `valid_out` is high.
- A `valid_in` on the cycle the last byte is emitted is still in REPLAY and is dropped. The first byte accepted into HUNT is the next one after that.
- Minimum spacing between accepted frames: zero idle cycles after replay ends.
- A byte arriving on the exact timeout edge is accepted, and the timeout does not fire.

## Test plan
- Good frame A5 03 01 02 03 03, `out_ready`=1: `frame_ok` 1 cycle after the CSUM edge, then `valid_out` carries 01, 02, 03 on consecutive cycles; `frame_err` never asserts.
- Same frame with CSUM 00: `frame_err` with `err_code`=2, no `valid_out`. A following good frame is replayed correctly.
- A5 00, and separately A5 41 (65 > 64): `frame_err` with code 1 for each. Then bytes 12 34 are ignored in HUNT with no pulse.
- A5 02 7E, then silence for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=100 in simulation): `frame_err` with code 3 and `busy`=0. A following good frame succeeds.
- L=64 frame with `out_ready` toggled 1-0-1: all 64 bytes delivered in order. Bytes injected during replay give `drop_count`=injected count, and `drop_count` saturates at 255 after 300 injections.
- `rst`=0 for 1 cycle in the middle of PAYLOAD: all outputs 0 and state HUNT, with no `frame_err`. The next frame A5 01 FF FE yields `frame_ok` and byte FF.

Source files
------------

// File: rtl/frame_checker.sv
// frame_checker: checks SYNC / LEN / payload / XOR-CSUM frames from uart_rx and forwards only intact payloads to parser.
// Latency: frame_ok 1 cycle after the CSUM byte edge; first payload byte 2 cycles after it, then one per out_ready cycle.
// Backpressure: out_ready stalls replay in place; uart_rx cannot be stalled, so bytes that arrive during replay are dropped and counted.
// Ports: clk, rst (synchronous, active-low); valid_in/byte_in from uart_rx; out_ready/valid_out/byte_out to parser;
//        frame_ok/frame_err/err_code per-frame status pulses; busy and drop_count for the debug probes.
module frame_checker #(
  parameter int unsigned MAX_PAYLOAD    = 64,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] byte_in,
  input  logic       out_ready,
  output logic       valid_out,
  output logic [7:0] byte_out,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [8:0]    MAX_LEN   = 9'(MAX_PAYLOAD);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, REPLAY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] last_idx, last_nxt;   // L-1, index of the final payload byte
  logic [AW-1:0] wr_idx, wr_nxt;
  logic [AW-1:0] rd_idx, rd_nxt;
  logic [7:0]    xor_acc, xor_nxt;
  logic [TW-1:0] idle_cnt, idle_nxt;
  logic [7:0]    pay_buf [MAX_PAYLOAD];
  logic          buf_we;

  logic       valid_out_nxt, frame_ok_nxt, frame_err_nxt, busy_nxt;
  logic [7:0] byte_out_nxt, drop_count_nxt;
  logic [1:0] err_code_nxt;
  logic       in_frame;

  assign in_frame = (state == LEN) || (state == PAYLOAD) || (state == CSUM);

  always_comb begin
    state_nxt      = state;
    last_nxt       = last_idx;
    wr_nxt         = wr_idx;
    rd_nxt         = rd_idx;
    xor_nxt        = xor_acc;
    idle_nxt       = '0;
    buf_we         = 1'b0;
    valid_out_nxt  = 1'b0;
    byte_out_nxt   = byte_out;
    frame_ok_nxt   = 1'b0;
    frame_err_nxt  = 1'b0;
    err_code_nxt   = err_code;
    drop_count_nxt = drop_count;

    // A byte on the same edge the counter expires wins over the timeout.
    if (in_frame && !valid_in) begin
      if (idle_cnt == IDLE_LAST) begin
        state_nxt     = HUNT;
        frame_err_nxt = 1'b1;
        err_code_nxt  = ERR_TIMEOUT;
      end else begin
        idle_nxt = idle_cnt + 1'b1;
      end
    end

    case (state)
      HUNT: begin
        rd_nxt = '0;
        if (valid_in && byte_in == SYNC_BYTE) state_nxt = LEN;
      end
      LEN: begin
        if (valid_in) begin
          if (byte_in == 8'd0 || {1'b0, byte_in} > MAX_LEN) begin
            state_nxt     = HUNT;
            frame_err_nxt = 1'b1;
            err_code_nxt  = ERR_LEN;
          end else begin
            last_nxt  = AW'(byte_in - 8'd1);
            xor_nxt   = byte_in;
            wr_nxt    = '0;
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (valid_in) begin
          buf_we  = 1'b1;
          wr_nxt  = wr_idx + 1'b1;
          xor_nxt = xor_acc ^ byte_in;
          if (wr_idx == last_idx) state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (valid_in) begin
          if (byte_in == xor_acc) begin
            state_nxt    = REPLAY;
            frame_ok_nxt = 1'b1;
            rd_nxt       = '0;
          end else begin
            state_nxt     = HUNT;
            frame_err_nxt = 1'b1;
            err_code_nxt  = ERR_CSUM;
          end
        end
      end
      REPLAY: begin
        if (valid_in && drop_count != 8'hFF) drop_count_nxt = drop_count + 8'd1;
        if (out_ready) begin
          valid_out_nxt = 1'b1;
          byte_out_nxt  = pay_buf[rd_idx];
          rd_nxt        = rd_idx + 1'b1;
          if (rd_idx == last_idx) state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase

    busy_nxt = (state_nxt != HUNT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HUNT;
      last_idx   <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      xor_acc    <= '0;
      idle_cnt   <= '0;
      valid_out  <= 1'b0;
      byte_out   <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
      drop_count <= '0;
    end else begin
      state      <= state_nxt;
      last_idx   <= last_nxt;
      wr_idx     <= wr_nxt;
      rd_idx     <= rd_nxt;
      xor_acc    <= xor_nxt;
      idle_cnt   <= idle_nxt;
      valid_out  <= valid_out_nxt;
      byte_out   <= byte_out_nxt;
      frame_ok   <= frame_ok_nxt;
      frame_err  <= frame_err_nxt;
      err_code   <= err_code_nxt;
      busy       <= busy_nxt;
      drop_count <= drop_count_nxt;
    end
  end

  // Payload storage needs no reset: every accepted frame rewrites indices 0..L-1 before replay reads them.
  always_ff @(posedge clk) begin
    if (buf_we) pay_buf[wr_idx] <= byte_in;
  end

endmodule

// File: tb/tb_frame_checker.sv
module tb_frame_checker;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst, valid_in, out_ready;
  logic [7:0] byte_in;
  logic       valid_out, frame_ok, frame_err, busy;
  logic [7:0] byte_out, drop_count;
  logic [1:0] err_code;

  frame_checker #(.MAX_PAYLOAD(64), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .byte_in(byte_in), .out_ready(out_ready),
    .valid_out(valid_out), .byte_out(byte_out), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Monitor: collects what the DUT emits, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int         vo_cyc_q[$];
  int         ok_cnt = 0, err_cnt = 0, both_cnt = 0, ok_cyc = -1;
  logic [1:0] last_code = 2'd0;
  logic       vo_busy_last = 1'b0;

  always @(negedge clk) begin
    if (valid_out) begin
      rx_q.push_back(byte_out);
      vo_cyc_q.push_back(cyc);
      vo_busy_last = busy;
    end
    if (frame_ok) begin
      ok_cnt++;
      ok_cyc = cyc;
    end
    if (frame_err) begin
      err_cnt++;
      last_code = err_code;
    end
    if (frame_ok && frame_err) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] pay[$];
  int         csum_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Idle for 'gap' cycles, then present one byte for one edge.
  task automatic put_byte(input logic [7:0] b, input int gap);
    valid_in = 1'b0;
    tick(gap);
    valid_in = 1'b1;
    byte_in  = b;
    tick(1);
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input bit bad, input int maxgap);
    logic [7:0] cs;
    cs = 8'(pay.size());
    foreach (pay[i]) cs ^= pay[i];
    if (bad) cs ^= 8'(1 << $urandom_range(0, 7));
    put_byte(8'hA5, $urandom_range(0, maxgap));
    put_byte(8'(pay.size()), $urandom_range(0, maxgap));
    foreach (pay[i]) put_byte(pay[i], $urandom_range(0, maxgap));
    put_byte(cs, $urandom_range(0, maxgap));
    csum_edge = cyc;
  endtask

  // Send the frame in 'pay' and compare the outcome with what the framing rules predict.
  task automatic run_frame(input string tag, input bit bad, input int maxgap, input bit rnd_rdy);
    int  rb, ob, eb, L;
    bit  done;
    rb = rx_q.size(); ob = ok_cnt; eb = err_cnt; L = pay.size();
    send_frame(bad, maxgap);
    if (!bad) begin
      done = 1'b0;
      for (int k = 0; k < 4000 && !done; k++) begin
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        tick(1);
        done = (rx_q.size() >= rb + L);
      end
      out_ready = 1'b1;
    end
    tick(3);
    chk({tag, "_ok"},  ok_cnt - ob,  bad ? 0 : 1);
    chk({tag, "_err"}, err_cnt - eb, bad ? 1 : 0);
    if (bad) chk({tag, "_code"}, last_code, 2);
    chk({tag, "_nbytes"}, rx_q.size() - rb, bad ? 0 : L);
    if (!bad)
      for (int i = 0; i < L; i++)
        if (rb + i < rx_q.size()) chk({tag, "_byte"}, rx_q[rb + i], pay[i]);
    chk({tag, "_busy"}, busy, 0);
  endtask

  int rb, ob, eb, injected, seen, dbefore;
  bit inj, prev_rdy, bad;
  logic [7:0] junk;

  initial begin
    rst = 1'b0; valid_in = 1'b0; byte_in = 8'h00; out_ready = 1'b0;
    tick(3);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_flags", {frame_ok, frame_err, busy}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b1; out_ready = 1'b1;
    tick(2);

    // Reference good frame, with exact timing.
    pay = '{8'h01, 8'h02, 8'h03};
    rb = rx_q.size();
    run_frame("good3", 1'b0, 0, 1'b0);
    chk("good3_ok_cycle", ok_cyc, csum_edge);
    if (rx_q.size() >= rb + 3) begin
      chk("good3_first_vo_cycle", vo_cyc_q[rb], csum_edge + 1);
      chk("good3_last_vo_cycle", vo_cyc_q[rb + 2], csum_edge + 3);
    end
    chk("good3_busy_at_last", vo_busy_last, 0);

    // Same frame with a wrong checksum, then a good one.
    ob = err_cnt; rb = rx_q.size();
    put_byte(8'hA5, 0); put_byte(8'h03, 0); put_byte(8'h01, 0);
    put_byte(8'h02, 0); put_byte(8'h03, 0); put_byte(8'h00, 0);
    chk("csum00_err_pulse", {frame_err, frame_ok, err_code}, {1'b1, 1'b0, 2'd2});
    tick(3);
    chk("csum00_no_output", rx_q.size() - rb, 0);
    chk("csum00_err_count", err_cnt - ob, 1);
    pay = '{8'hA5, 8'h5A};
    run_frame("after_csum", 1'b0, 2, 1'b0);

    // Length errors, then junk ignored in HUNT.
    put_byte(8'hA5, 0); put_byte(8'h00, 0);
    chk("len0_err", {frame_err, err_code, busy}, {1'b1, 2'd1, 1'b0});
    tick(1);
    put_byte(8'hA5, 1); put_byte(8'h41, 0);
    chk("len65_err", {frame_err, err_code, busy}, {1'b1, 2'd1, 1'b0});
    tick(2);
    ob = ok_cnt; eb = err_cnt;
    put_byte(8'h12, 0); put_byte(8'h34, 0);
    tick(3);
    chk("junk_no_pulse", (ok_cnt - ob) + (err_cnt - eb), 0);
    chk("junk_busy", busy, 0);

    // Timeout: fires after T idle cycles, not before.
    put_byte(8'hA5, 0); put_byte(8'h02, 0); put_byte(8'h7E, 0);
    tick(T - 1);
    chk("timeout_early", {frame_err, busy}, {1'b0, 1'b1});
    tick(1);
    chk("timeout_fire", {frame_err, err_code}, {1'b1, 2'd3});
    chk("timeout_busy", busy, 0);
    tick(2);
    // A byte arriving exactly on the expiry edge is accepted.
    ob = ok_cnt; rb = rx_q.size();
    put_byte(8'hA5, 0); put_byte(8'h02, T - 1); put_byte(8'h7E, T - 1);
    put_byte(8'h11, T - 1); put_byte(8'h02 ^ 8'h7E ^ 8'h11, T - 1);
    tick(4);
    chk("edge_byte_ok", ok_cnt - ob, 1);
    chk("edge_byte_nbytes", rx_q.size() - rb, 2);
    pay = '{8'hC3};
    run_frame("after_timeout", 1'b0, 0, 1'b0);

    // Randomized frames with HUNT junk, gaps, corrupted checksums and random out_ready.
    for (int f = 0; f < 8; f++) begin
      junk = 8'($urandom);
      if (junk == 8'hA5) junk = 8'h5A;
      put_byte(junk, $urandom_range(0, 3));
      pay.delete();
      for (int i = 0; i < $urandom_range(1, 64); i++) pay.push_back(8'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      run_frame("rand", bad, 3, 1'b1);
    end

    // Max-length frame, out_ready toggled, bytes injected during replay.
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom));
    rb = rx_q.size(); dbefore = drop_count; ob = ok_cnt;
    out_ready = 1'b0;
    send_frame(1'b0, 0);
    injected = 0; seen = 0;
    for (int k = 0; k < 1000 && seen < 64; k++) begin
      out_ready = (k < 3) ? (k != 1) : 1'($urandom_range(0, 1));
      inj = (seen == 63) || ($urandom_range(0, 1) == 1);
      valid_in = inj;
      byte_in = 8'($urandom);
      prev_rdy = out_ready;
      tick(1);
      if (valid_out) seen++;
      if (!prev_rdy) chk("l64_stall", valid_out, 0);
      if (inj) injected++;
    end
    valid_in = 1'b0; out_ready = 1'b1;
    tick(3);
    chk("l64_ok", ok_cnt - ob, 1);
    chk("l64_nbytes", rx_q.size() - rb, 64);
    for (int i = 0; i < 64; i++)
      if (rb + i < rx_q.size()) chk("l64_byte", rx_q[rb + i], pay[i]);
    chk("l64_drop", drop_count, dbefore + injected);
    chk("l64_busy", busy, 0);

    // drop_count saturation while replay is held off.
    pay = '{8'h3C};
    out_ready = 1'b0;
    send_frame(1'b0, 0);
    for (int k = 0; k < 300; k++) begin
      valid_in = 1'b1;
      byte_in = 8'($urandom);
      tick(1);
    end
    valid_in = 1'b0;
    tick(1);
    chk("drop_sat", drop_count, 255);
    chk("drop_sat_busy", busy, 1);
    rb = rx_q.size();
    out_ready = 1'b1;
    tick(4);
    chk("drop_sat_nbytes", rx_q.size() - rb, 1);
    if (rx_q.size() > rb) chk("drop_sat_byte", rx_q[rb], 8'h3C);

    // Reset in the middle of PAYLOAD.
    eb = err_cnt;
    put_byte(8'hA5, 0); put_byte(8'h05, 0); put_byte(8'h11, 0); put_byte(8'h22, 0);
    rst = 1'b0;
    tick(1);
    chk("midrst_outputs", {valid_out, frame_ok, frame_err, busy}, 0);
    chk("midrst_byte_out", byte_out, 0);
    chk("midrst_err_code", err_code, 0);
    chk("midrst_drop", drop_count, 0);
    rst = 1'b1;
    tick(2);
    chk("midrst_no_err", err_cnt - eb, 0);
    pay = '{8'hFF};
    run_frame("after_rst", 1'b0, 0, 1'b0);

    chk("ok_err_never_together", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
